johnson_phase_sequencer: RTL and testbench
==========================================

Name: johnson_phase_sequencer

Overview:
- Controller that sequences an internal WIDTH-bit Johnson counter through a programmed number of full rotations. Each rotation is 2*WIDTH phases.
- Decodes the current counter state into a phase index and a one-hot phase strobe.
- Used to time-slot a shared resource across 2*WIDTH consumers, e.g. multi-phase enables and round-robin access windows.
- Provides start/stop/done handshaking to an upstream control FSM.

Parameters:
- WIDTH, 4, Johnson counter width; number of phases NPH = 2*WIDTH. Must be >= 2.
- CNT_W, 8, width of the rotation count.
- Derived localparam PH_W = $clog2(2*WIDTH), the phase index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sequence; sampled in IDLE only.
- rotations  input  CNT_W  number of full rotations to run; sampled with start.
- stop  input  1  graceful stop request; sampled in RUN only.
- step_en  input  1  advance enable; counter steps on edges where RUN and step_en are both 1.
- busy  output  1  1 while in RUN.
- done  output  1  registered one-cycle pulse when a sequence completes.
- phase_valid  output  1  equals busy.
- phase_idx  output  PH_W  decoded phase, 0..NPH-1; 0 when IDLE.
- phase_onehot  output  NPH  equals 1<<phase_idx when phase_valid, otherwise all zeros.
- count  output  WIDTH  raw Johnson state.
- rot_left  output  CNT_W  rotations remaining, including the current one.
- illegal_state  output  1  registered pulse; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0) sets the FSM to IDLE and clears to zero: count, rot_left, stop_pending, done, illegal_state. Consequently busy=0, phase_valid=0, phase_idx=0, phase_onehot=0.
- FSM states are IDLE and RUN.
- Johnson step rule: count <= {~count[0], count[WIDTH-1:1]}. For WIDTH=4 the sequence is 0000,1000,1100,1110,1111,0111,0011,0001, then back to 0000.
- Phase decode, with p = popcount(count):
  - If count[WIDTH-1]=1, idx = p.
  - Else if p=0, idx = 0.
  - Else idx = NPH - p.
  - Phase NPH-1 is state 0...01.
- IDLE, start=1 and rotations!=0: at the edge, go to RUN, load rot_left=rotations, set count=0, clear stop_pending. busy and phase_valid are 1 from the next cycle, with phase_idx=0.
- IDLE, start=1 and rotations=0: ignored, no done pulse.
- IDLE, stop=1: ignored. If start and stop are both 1 in IDLE, start wins.
- RUN, step_en=0: all state holds.
- RUN, step_en=1, phase_idx != NPH-1: count advances one step.
- RUN, step_en=1, phase_idx == NPH-1 (end of a rotation): count wraps to 0 and rot_left decrements.
  - If rot_left was 1, or stop_pending is set, or stop=1 on this cycle: go to IDLE, set rot_left=0, and assert done for exactly the next cycle.
- RUN, stop=1 on any cycle: sets stop_pending. The current rotation completes and no further rotation starts.
- RUN, start=1: ignored; rotations are not re-sampled.
- Latency: with step_en held at 1, busy stays high for exactly rotations*NPH cycles. done rises on the first cycle after busy falls.
- A new start is accepted on the cycle done is high, since the FSM is already in IDLE.
- Reset mid-sequence: immediate return to the reset values. No done pulse is generated.
- rot_left arithmetic is unsigned and never underflows; it is only decremented in RUN, where it is >= 1.

Optional Feature:
- Macro: JOHNSON_SELF_CORRECT_EN.
- Enabled:
  - A combinational checker flags any count value outside the 2*WIDTH legal states.
  - If the FSM is in RUN and the state is illegal, the next edge forces count=0 (phase 0), independent of step_en. rot_left and stop_pending are unchanged.
  - illegal_state pulses high for one cycle after that edge.
  - In IDLE an illegal count is also forced to 0 and flagged.
- Disabled: no checker is present, illegal_state is tied to 0, and count follows only the step rule.

Test Plan:
- WIDTH=4, start with rotations=2, step_en=1 -> busy high 16 cycles; phase_idx 0..7 twice; phase_onehot 0x01..0x80; count 0000→1000→…→0001; done pulse 1 cycle after busy falls; rot_left 2→1→0.
- rotations=1, step_en toggling 1,0,1,0… -> each phase held 2 cycles; busy high 16 cycles; exactly one done pulse.
- rotations=3, stop pulsed at phase_idx=3 of rotation 1 -> rotation 1 completes through phase 7, then IDLE and done; rot_left jumps to 0; total busy 8 cycles.
- start with rotations=0; start during RUN with rotations=5; stop in IDLE -> no state change; rot_left is not reloaded during RUN; no spurious done.
- rst_n asserted at phase_idx=5 of a run with rotations=4 -> all outputs zero asynchronously; no done; a subsequent start with rotations=1 runs a normal 8-cycle sequence.
- JOHNSON_SELF_CORRECT_EN defined: force count=0101 in RUN -> next edge count=0000 and phase_idx=0; illegal_state pulses once; rot_left unchanged. With the macro undefined, illegal_state stays 0.

Source files
------------

// File: rtl/johnson_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// johnson_phase_sequencer_if
//
// Bundles the control handshake and the phase outputs of the Johnson phase
// sequencer.  The master side (upstream control FSM) drives the requests;
// the slave side (the sequencer) drives status and phase outputs.
//
// Handshake semantics:
//   start/rotations : one-cycle request, accepted only while busy is 0 and
//                     rotations is non-zero; start while busy is 1 is ignored.
//                     There is no ready signal: !busy is the ready condition.
//   stop            : graceful stop request, meaningful only while busy is 1;
//                     the rotation in progress always completes.
//   done            : one-cycle pulse on the first cycle after busy falls at
//                     the normal end of a sequence (never after reset).
//
// Signals:
//   start, rotations, stop, step_en       master -> slave
//   busy, done, phase_valid, phase_idx,
//   phase_onehot, count, rot_left,
//   illegal_state, state_dbg               slave -> master
//   state_dbg exposes the FSM state (0 = IDLE, 1 = RUN).
// ---------------------------------------------------------------------------
interface johnson_phase_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  localparam int NPH  = 2 * WIDTH;
  localparam int PH_W = $clog2(NPH);

  logic             start;
  logic [CNT_W-1:0] rotations;
  logic             stop;
  logic             step_en;

  logic             busy;
  logic             done;
  logic             phase_valid;
  logic [PH_W-1:0]  phase_idx;
  logic [NPH-1:0]   phase_onehot;
  logic [WIDTH-1:0] count;
  logic [CNT_W-1:0] rot_left;
  logic             illegal_state;
  logic             state_dbg;

  modport master (
    output start, rotations, stop, step_en,
    input  busy, done, phase_valid, phase_idx, phase_onehot, count,
           rot_left, illegal_state, state_dbg
  );

  modport slave (
    input  start, rotations, stop, step_en,
    output busy, done, phase_valid, phase_idx, phase_onehot, count,
           rot_left, illegal_state, state_dbg
  );
endinterface

// File: rtl/johnson_phase_sequencer.sv
// ---------------------------------------------------------------------------
// johnson_phase_sequencer
//
// Steps a WIDTH-bit Johnson counter through a programmed number of full
// rotations (2*WIDTH phases each), decoding the counter into a phase index
// and a one-hot phase strobe for time-slotting a shared resource.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - johnson_phase_sequencer_if.slave: start/rotations/stop/step_en
//            in; busy/done/phase_valid/phase_idx/phase_onehot/count/
//            rot_left/illegal_state/state_dbg out
//
// Optional feature (macro JOHNSON_SELF_CORRECT_EN):
//   When defined, any count value outside the 2*WIDTH legal Johnson states
//   is forced back to 0 on the next edge (in IDLE or RUN, regardless of
//   step_en) and illegal_state pulses for one cycle.  When undefined,
//   illegal_state is tied to 0.
// ---------------------------------------------------------------------------
module johnson_phase_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  johnson_phase_sequencer_if.slave bus
);
  localparam int NPH  = 2 * WIDTH;
  localparam int PH_W = $clog2(NPH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] count_step;
  logic [CNT_W-1:0] rot_q, rot_d;
  logic             stop_pend_q, stop_pend_d;
  logic             done_q, done_d;
  logic [PH_W:0]    pop;
  logic [PH_W-1:0]  idx;
  logic             at_last;
  logic             illegal;
  logic             busy;

  assign count_step = {~count_q[0], count_q[WIDTH-1:1]};

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + (PH_W+1)'(count_q[i]);
  end

  // Leading-ones states (MSB set) are phases 1..WIDTH; trailing-ones states
  // are phases WIDTH+1..NPH-1, counted down from NPH by the number of ones.
  always_comb begin
    if (count_q[WIDTH-1])  idx = pop[PH_W-1:0];
    else if (pop == '0)    idx = '0;
    else                   idx = PH_W'((PH_W+1)'(NPH) - pop);
  end

  assign at_last = (idx == PH_W'(NPH - 1));

`ifdef JOHNSON_SELF_CORRECT_EN
  logic [WIDTH-1:0] thermo;
  logic             illegal_q;

  // A legal state is a solid run of ones anchored at the MSB (leading) or at
  // the LSB (trailing); rebuild that pattern from the popcount and compare.
  always_comb begin
    if (count_q[WIDTH-1]) thermo = ~({WIDTH{1'b1}} >> pop);
    else                  thermo = {WIDTH{1'b1}} >> (WIDTH - int'(pop));
  end

  assign illegal = (count_q != thermo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal;
  end

  assign bus.illegal_state = illegal_q;
`else
  assign illegal           = 1'b0;
  assign bus.illegal_state = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rot_q       <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rot_q       <= rot_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rot_d       = rot_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.rotations != '0)) begin
          state_d     = RUN;
          rot_d       = bus.rotations;
          count_d     = '0;
          stop_pend_d = 1'b0;
        end else if (illegal) begin
          count_d = '0;
        end
      end
      RUN: begin
        if (bus.stop) stop_pend_d = 1'b1;
        // Correction takes priority over stepping so a corrupted state can
        // never be mistaken for the end of a rotation.
        if (illegal) begin
          count_d = '0;
        end else if (bus.step_en) begin
          if (at_last) begin
            count_d = '0;
            if ((rot_q == CNT_W'(1)) || stop_pend_q || bus.stop) begin
              state_d = IDLE;
              rot_d   = '0;
              done_d  = 1'b1;
            end else begin
              rot_d = rot_q - CNT_W'(1);
            end
          end else begin
            count_d = count_step;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy             = (state_q == RUN);
  assign bus.busy         = busy;
  assign bus.phase_valid  = busy;
  assign bus.phase_idx    = busy ? idx : '0;
  assign bus.phase_onehot = busy ? (NPH'(1) << idx) : '0;
  assign bus.count        = count_q;
  assign bus.rot_left     = rot_q;
  assign bus.done         = done_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_johnson_phase_sequencer.sv
module tb_johnson_phase_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int NPH   = 2 * WIDTH;
  localparam int PH_W  = $clog2(NPH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [WIDTH-1:0] exp_q[$];

  johnson_phase_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  johnson_phase_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tracks the sequence as an integer phase number and a rotation budget.
  bit m_run, m_stop, m_done;
  int m_rot, m_ph;

  // Johnson pattern for a phase: phases 0..WIDTH fill ones from the MSB,
  // later phases drain them so that NPH-ph ones remain at the LSB end.
  function automatic logic [WIDTH-1:0] exp_count(int ph);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ph <= WIDTH) v[WIDTH-1-i] = (i < ph);
      else             v[i] = (i < NPH - ph);
    end
    return v;
  endfunction

  function automatic logic [NPH-1:0] exp_onehot();
    logic [NPH-1:0] v;
    v = '0;
    if (m_run) v[m_ph] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_stop = 0; m_done = 0; m_rot = 0; m_ph = 0;
  endtask

  task automatic model_edge(bit st, int rot, bit sp, bit se);
    m_done = 0;
    if (!m_run) begin
      if (st && rot != 0) begin
        m_run = 1; m_rot = rot; m_ph = 0; m_stop = 0;
      end
    end else begin
      if (se) begin
        if (m_ph == NPH - 1) begin
          m_ph = 0;
          if (m_rot == 1 || m_stop || sp) begin
            m_run = 0; m_rot = 0; m_done = 1;
          end else begin
            m_rot = m_rot - 1;
          end
        end else begin
          m_ph = m_ph + 1;
        end
      end
      if (sp) m_stop = 1;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives for one rising edge and returns at the
  // next falling edge where outputs are sampled.
  task automatic run_cycle(bit st, int rot, bit sp, bit se);
    bus.start     = st;
    bus.rotations = CNT_W'(rot);
    bus.stop      = sp;
    bus.step_en   = se;
    @(posedge clk);
    model_edge(st, rot, sp, se);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (m_run && n < 200) begin
      run_cycle(0, 0, 0, 1);
      n++;
    end
    checks++;
    if (m_run || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_timeout: busy=%0b expected 0", bus.busy);
    end
    run_cycle(0, 0, 0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 0; bus.rotations = '0; bus.stop = 0; bus.step_en = 0;
    rst_n = 0;
    model_reset();
    #12;
    checks++;
    if ({bus.busy, bus.phase_valid, bus.done, bus.illegal_state, bus.state_dbg} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: busy/valid/done/illegal/state=%b expected 00000",
               {bus.busy, bus.phase_valid, bus.done, bus.illegal_state, bus.state_dbg});
    end
    checks++;
    if ({bus.count, bus.rot_left, bus.phase_idx, bus.phase_onehot} !== '0) begin
      failures++;
      $display("FAIL reset_values: count=%0h rot_left=%0d idx=%0d onehot=%0h expected all 0",
               bus.count, bus.rot_left, bus.phase_idx, bus.phase_onehot);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_full_rotation();
    logic [WIDTH-1:0] tbl [NPH];
    logic [WIDTH-1:0] e;
    int busy_n = 0, dones = 0;
    tbl = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
    exp_q.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NPH; p++) exp_q.push_back(tbl[p]);
    run_cycle(1, 2, 0, 1);
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b1) begin
        busy_n++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (bus.count !== e) begin
          failures++;
          $display("FAIL full_count: cycle %0d got %b expected %b", i, bus.count, e);
        end
      end
      checks++;
      if (bus.phase_idx !== PH_W'(m_ph) || bus.phase_onehot !== exp_onehot()) begin
        failures++;
        $display("FAIL full_phase: cycle %0d idx=%0d onehot=%0h expected %0d %0h",
                 i, bus.phase_idx, bus.phase_onehot, m_ph, exp_onehot());
      end
      checks++;
      if (bus.rot_left !== CNT_W'(m_rot) || bus.done !== m_done) begin
        failures++;
        $display("FAIL full_rot_done: cycle %0d rot_left=%0d done=%0b expected %0d %0b",
                 i, bus.rot_left, bus.done, m_rot, m_done);
      end
      if (bus.done === 1'b1) dones++;
      run_cycle(0, 0, 0, 1);
    end
    checks++;
    if (busy_n != 16 || dones != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_totals: busy=%0d done=%0d leftover=%0d expected 16 1 0",
               busy_n, dones, exp_q.size());
    end
  endtask

  task automatic test_step_toggle();
    int busy_n = 0, dones = 0;
    run_cycle(1, 1, 0, 0);
    for (int i = 0; i < 22; i++) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) dones++;
      checks++;
      if (bus.busy !== m_run || bus.phase_idx !== PH_W'(m_run ? m_ph : 0) || bus.count !== exp_count(m_ph)) begin
        failures++;
        $display("FAIL toggle_phase: cycle %0d busy=%0b idx=%0d count=%b expected %0b %0d %b",
                 i, bus.busy, bus.phase_idx, bus.count, m_run, m_ph, exp_count(m_ph));
      end
      run_cycle(0, 0, 0, (i % 2) == 1);
    end
    checks++;
    if (busy_n != 16 || dones != 1) begin
      failures++;
      $display("FAIL toggle_totals: busy=%0d done=%0d expected 16 1", busy_n, dones);
    end
  endtask

  task automatic test_stop();
    int busy_n = 0, dones = 0;
    bit sent = 0;
    bit sp;
    run_cycle(1, 3, 0, 1);
    for (int i = 0; i < 30; i++) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) dones++;
      checks++;
      if (bus.rot_left !== CNT_W'(m_rot) || bus.busy !== m_run || bus.done !== m_done) begin
        failures++;
        $display("FAIL stop_state: cycle %0d rot_left=%0d busy=%0b done=%0b expected %0d %0b %0b",
                 i, bus.rot_left, bus.busy, bus.done, m_rot, m_run, m_done);
      end
      sp = m_run && m_ph == 3 && !sent;
      if (sp) sent = 1;
      run_cycle(0, 0, sp, 1);
    end
    checks++;
    if (busy_n != 8 || dones != 1) begin
      failures++;
      $display("FAIL stop_totals: busy=%0d done=%0d expected 8 1", busy_n, dones);
    end
  endtask

  task automatic test_ignored();
    int busy_n = 0, dones = 0;
    run_cycle(1, 0, 0, 1);
    run_cycle(0, 0, 1, 1);
    run_cycle(0, 0, 0, 1);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rot_left !== '0) begin
      failures++;
      $display("FAIL ignored_idle: busy=%0b done=%0b rot_left=%0d expected 0 0 0",
               bus.busy, bus.done, bus.rot_left);
    end
    // start and stop together in IDLE: start is taken, stop has no effect
    run_cycle(1, 1, 1, 1);
    for (int i = 0; i < 12; i++) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) dones++;
      checks++;
      if (bus.rot_left !== CNT_W'(m_rot) || bus.busy !== m_run || bus.done !== m_done) begin
        failures++;
        $display("FAIL ignored_run: cycle %0d rot_left=%0d busy=%0b done=%0b expected %0d %0b %0b",
                 i, bus.rot_left, bus.busy, bus.done, m_rot, m_run, m_done);
      end
      if (i == 2) run_cycle(1, 5, 0, 1);
      else        run_cycle(0, 0, 0, 1);
    end
    checks++;
    if (busy_n != 8 || dones != 1) begin
      failures++;
      $display("FAIL ignored_totals: busy=%0d done=%0d expected 8 1", busy_n, dones);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, busy_n = 0, dones = 0;
    run_cycle(1, 4, 0, 1);
    while (m_ph != 5 && n < 20) begin
      run_cycle(0, 0, 0, 1);
      n++;
    end
    checks++;
    if (bus.phase_idx !== PH_W'(5)) begin
      failures++;
      $display("FAIL rstmid_reach: idx=%0d expected 5", bus.phase_idx);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.count, bus.rot_left, bus.phase_idx, bus.phase_onehot} !== '0) begin
      failures++;
      $display("FAIL rstmid_async: busy=%0b done=%0b count=%b rot_left=%0d idx=%0d onehot=%0h expected all 0",
               bus.busy, bus.done, bus.count, bus.rot_left, bus.phase_idx, bus.phase_onehot);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 0, 0, 1);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL rstmid_nodone: done pulses=%0d expected 0", dones);
    end
    run_cycle(1, 1, 0, 1);
    for (int i = 0; i < 12; i++) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) dones++;
      run_cycle(0, 0, 0, 1);
    end
    checks++;
    if (busy_n != 8 || dones != 1) begin
      failures++;
      $display("FAIL rstmid_rerun: busy=%0d done=%0d expected 8 1", busy_n, dones);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, busy_n = 0, dones = 0;
    run_cycle(1, 1, 0, 1);
    while (!(bus.done === 1'b1) && n < 40) begin
      run_cycle(0, 0, 0, 1);
      n++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_done: done=%0b expected 1", bus.done);
    end
    run_cycle(1, 2, 0, 1);
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) dones++;
      checks++;
      if (bus.busy !== m_run || bus.count !== exp_count(m_ph) || bus.rot_left !== CNT_W'(m_rot)) begin
        failures++;
        $display("FAIL b2b_state: cycle %0d busy=%0b count=%b rot_left=%0d expected %0b %b %0d",
                 i, bus.busy, bus.count, bus.rot_left, m_run, exp_count(m_ph), m_rot);
      end
      run_cycle(0, 0, 0, 1);
    end
    checks++;
    if (busy_n != 16 || dones != 1) begin
      failures++;
      $display("FAIL b2b_totals: busy=%0d done=%0d expected 16 1", busy_n, dones);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3),
                $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
      checks++;
      if (bus.busy !== m_run || bus.phase_valid !== m_run || bus.done !== m_done ||
          bus.phase_idx !== PH_W'(m_run ? m_ph : 0) || bus.phase_onehot !== exp_onehot() ||
          bus.count !== exp_count(m_ph) || bus.rot_left !== CNT_W'(m_rot) ||
          bus.illegal_state !== 1'b0) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random: cycle %0d busy=%0b done=%0b idx=%0d onehot=%0h count=%b rot=%0d ill=%0b expected %0b %0b %0d %0h %b %0d 0",
                   i, bus.busy, bus.done, bus.phase_idx, bus.phase_onehot, bus.count,
                   bus.rot_left, bus.illegal_state, m_run, m_done, m_run ? m_ph : 0,
                   exp_onehot(), exp_count(m_ph), m_rot);
      end
    end
    drain();
  endtask

`ifdef JOHNSON_SELF_CORRECT_EN
  task automatic test_self_correct();
    int saved_rot;
    run_cycle(1, 2, 0, 1);
    run_cycle(0, 0, 0, 1);
    run_cycle(0, 0, 0, 1);
    saved_rot = m_rot;
    force dut.count_q = 4'b0101;
    #1 release dut.count_q;
    bus.start = 0; bus.stop = 0; bus.step_en = 0;
    @(posedge clk);
    m_ph = 0;
    @(negedge clk);
    checks++;
    if (bus.count !== 4'b0000 || bus.phase_idx !== '0 || bus.illegal_state !== 1'b1 ||
        bus.rot_left !== CNT_W'(saved_rot)) begin
      failures++;
      $display("FAIL self_correct: count=%b idx=%0d ill=%0b rot=%0d expected 0000 0 1 %0d",
               bus.count, bus.phase_idx, bus.illegal_state, bus.rot_left, saved_rot);
    end
    run_cycle(0, 0, 0, 1);
    checks++;
    if (bus.illegal_state !== 1'b0 || bus.count !== exp_count(m_ph)) begin
      failures++;
      $display("FAIL self_correct_pulse: ill=%0b count=%b expected 0 %b",
               bus.illegal_state, bus.count, exp_count(m_ph));
    end
    drain();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_full_rotation();
    drain();
    test_step_toggle();
    drain();
    test_stop();
    drain();
    test_ignored();
    drain();
    test_reset_mid();
    drain();
    test_back_to_back();
    drain();
`ifdef JOHNSON_SELF_CORRECT_EN
    test_self_correct();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
